// File: rtl/keyboard_cmd_pkg.sv
// Shared types for the keyboard command path: command codes, FSM states and
// board coordinates. The PS/2 decoder uses the same command enum.
package keyboard_cmd_pkg;

  localparam int PKG_COORD_W = 4;

  typedef enum logic [2:0] {
    CMD_UP     = 3'b000,
    CMD_LEFT   = 3'b001,
    CMD_DOWN   = 3'b010,
    CMD_RIGHT  = 3'b011,
    CMD_SELECT = 3'b100,
    CMD_HALF   = 3'b101,
    CMD_RSV6   = 3'b110,
    CMD_RSV7   = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MOVE_REQ,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [PKG_COORD_W-1:0] x;
    logic [PKG_COORD_W-1:0] y;
  } coord_t;

  // Direction commands are exactly the codes with the top bit clear.
  function automatic logic is_dir(cmd_e c);
    return ~c[2];
  endfunction

endpackage

// File: rtl/coord_stepper.sv
// One-cell step of a board coordinate in a given direction. off_edge_o flags
// a step that would leave the board; WRAP picks wrap-around vs. stay put.
module coord_stepper
  import keyboard_cmd_pkg::*;
#(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int WRAP    = 0
) (
  input  coord_t coord_i,
  input  cmd_e   dir_i,
  output coord_t next_o,
  output logic   off_edge_o
);

  localparam logic [PKG_COORD_W-1:0] XMAX = PKG_COORD_W'(BOARD_W - 1);
  localparam logic [PKG_COORD_W-1:0] YMAX = PKG_COORD_W'(BOARD_H - 1);

  always_comb begin
    next_o     = coord_i;
    off_edge_o = 1'b0;
    case (dir_i)
      CMD_UP: begin
        if (coord_i.y == '0) begin
          off_edge_o = 1'b1;
          if (WRAP != 0) next_o.y = YMAX;
        end else next_o.y = coord_i.y - 1'b1;
      end
      CMD_DOWN: begin
        if (coord_i.y == YMAX) begin
          off_edge_o = 1'b1;
          if (WRAP != 0) next_o.y = '0;
        end else next_o.y = coord_i.y + 1'b1;
      end
      CMD_LEFT: begin
        if (coord_i.x == '0) begin
          off_edge_o = 1'b1;
          if (WRAP != 0) next_o.x = XMAX;
        end else next_o.x = coord_i.x - 1'b1;
      end
      CMD_RIGHT: begin
        if (coord_i.x == XMAX) begin
          off_edge_o = 1'b1;
          if (WRAP != 0) next_o.x = '0;
        end else next_o.x = coord_i.x + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/keyboard_command_unit.sv
// Turns decoded key commands into cursor motion, selection/half flags and
// single-outstanding army-move requests held until the game logic acks.
module keyboard_command_unit
  import keyboard_cmd_pkg::*;
#(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int COORD_W = 4,
  parameter int WRAP    = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_ready,
  input  logic [2:0]         key_data,
  output logic               key_read_fin,
  input  logic               game_active,
  input  logic               cursor_load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               selected,
  output logic               half,
  output logic               move_valid,
  output logic [COORD_W-1:0] move_src_x,
  output logic [COORD_W-1:0] move_src_y,
  output logic [COORD_W-1:0] move_dst_x,
  output logic [COORD_W-1:0] move_dst_y,
  output logic               move_half,
  input  logic               move_ack,
  input  logic               move_ok
);

  if (COORD_W != PKG_COORD_W) begin : g_bad_coord_w
    $error("COORD_W must match keyboard_cmd_pkg::PKG_COORD_W");
  end

  state_e state_q, state_d;
  cmd_e   cmd_q, cmd_d;
  coord_t cur_q, cur_d, src_q, src_d, dst_q, dst_d;
  logic   fin_q, fin_d, sel_q, sel_d, half_q, half_d;
  logic   mv_q, mv_d, mhalf_q, mhalf_d;

  coord_t step_nxt, tgt_nxt, load_c;
  logic   step_off, tgt_off, move_go;

  // Cursor steps honour WRAP; move targets never wrap, only report off-board.
  coord_stepper #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .WRAP(WRAP)) u_cur_step (
    .coord_i(cur_q), .dir_i(cmd_q), .next_o(step_nxt), .off_edge_o(step_off)
  );
  coord_stepper #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .WRAP(0)) u_tgt_step (
    .coord_i(cur_q), .dir_i(cmd_q), .next_o(tgt_nxt), .off_edge_o(tgt_off)
  );

  assign load_c.x = (int'(load_x) > BOARD_W - 1) ? COORD_W'(BOARD_W - 1) : load_x;
  assign load_c.y = (int'(load_y) > BOARD_H - 1) ? COORD_W'(BOARD_H - 1) : load_y;
  assign move_go  = game_active && is_dir(cmd_q) && sel_q && !tgt_off;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_UP;
      fin_q   <= 1'b0;
      cur_q   <= '0;
      sel_q   <= 1'b0;
      half_q  <= 1'b0;
      mv_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      mhalf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      fin_q   <= fin_d;
      cur_q   <= cur_d;
      sel_q   <= sel_d;
      half_q  <= half_d;
      mv_q    <= mv_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      mhalf_q <= mhalf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (key_ready) state_d = ST_EXEC;
      ST_EXEC:     state_d = move_go ? ST_MOVE_REQ : ST_DRAIN;
      ST_MOVE_REQ: if (move_ack) state_d = ST_DRAIN;
      ST_DRAIN:    if (!key_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d   = cmd_q;
    fin_d   = 1'b0;
    cur_d   = cur_q;
    sel_d   = sel_q;
    half_d  = half_q;
    mv_d    = mv_q;
    src_d   = src_q;
    dst_d   = dst_q;
    mhalf_d = mhalf_q;
    if (state_q == ST_IDLE && key_ready) begin
      cmd_d = cmd_e'(key_data);
      fin_d = 1'b1;
    end
    if (state_q == ST_EXEC && game_active) begin
      case (cmd_q)
        CMD_SELECT: sel_d = ~sel_q;
        CMD_HALF:   if (sel_q) half_d = ~half_q;
        CMD_UP, CMD_LEFT, CMD_DOWN, CMD_RIGHT: begin
          if (!sel_q) cur_d = step_nxt;
          else if (!tgt_off) begin
            src_d   = cur_q;
            dst_d   = tgt_nxt;
            mhalf_d = half_q;
            mv_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (state_q == ST_MOVE_REQ && move_ack) begin
      mv_d   = 1'b0;
      half_d = 1'b0;
      if (move_ok) cur_d = dst_q;
      else         sel_d = 1'b0;
    end
    // A load overrides any cursor/flag update from the same cycle's ack.
    if (cursor_load) begin
      cur_d  = load_c;
      sel_d  = 1'b0;
      half_d = 1'b0;
    end
  end

  assign key_read_fin = fin_q;
  assign cursor_x     = cur_q.x;
  assign cursor_y     = cur_q.y;
  assign selected     = sel_q;
  assign half         = half_q;
  assign move_valid   = mv_q;
  assign move_src_x   = src_q.x;
  assign move_src_y   = src_q.y;
  assign move_dst_x   = dst_q.x;
  assign move_dst_y   = dst_q.y;
  assign move_half    = mhalf_q;

endmodule

// File: tb/tb_keyboard_command_unit.sv
// Drives a clamp (WRAP=0) and a wrap (WRAP=1) instance with identical key
// traffic and checks both against a rule-level model every cycle.
module tb_keyboard_command_unit;

  localparam int W = 16;
  localparam int H = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_ready = 1'b0;
  logic [2:0] key_data = 3'b000;
  logic game_active = 1'b1;
  logic cursor_load = 1'b0;
  logic [3:0] load_x = 4'd0, load_y = 4'd0;
  logic move_ack = 1'b0, move_ok = 1'b0;

  logic       fin [2];
  logic [3:0] cx [2], cy [2], sx [2], sy [2], dx [2], dy [2];
  logic       sel [2], hlf [2], mv [2], mh [2];

  always #5 clock = ~clock;

  keyboard_command_unit #(.BOARD_W(W), .BOARD_H(H), .COORD_W(4), .WRAP(0)) u_dut0 (
    .clock(clock), .reset(reset), .key_ready(key_ready), .key_data(key_data),
    .key_read_fin(fin[0]), .game_active(game_active), .cursor_load(cursor_load),
    .load_x(load_x), .load_y(load_y), .cursor_x(cx[0]), .cursor_y(cy[0]),
    .selected(sel[0]), .half(hlf[0]), .move_valid(mv[0]),
    .move_src_x(sx[0]), .move_src_y(sy[0]), .move_dst_x(dx[0]), .move_dst_y(dy[0]),
    .move_half(mh[0]), .move_ack(move_ack), .move_ok(move_ok)
  );

  keyboard_command_unit #(.BOARD_W(W), .BOARD_H(H), .COORD_W(4), .WRAP(1)) u_dut1 (
    .clock(clock), .reset(reset), .key_ready(key_ready), .key_data(key_data),
    .key_read_fin(fin[1]), .game_active(game_active), .cursor_load(cursor_load),
    .load_x(load_x), .load_y(load_y), .cursor_x(cx[1]), .cursor_y(cy[1]),
    .selected(sel[1]), .half(hlf[1]), .move_valid(mv[1]),
    .move_src_x(sx[1]), .move_src_y(sy[1]), .move_dst_x(dx[1]), .move_dst_y(dy[1]),
    .move_half(mh[1]), .move_ack(move_ack), .move_ok(move_ok)
  );

  // Rule-level model, one slot per instance (index == WRAP setting).
  int m_x [2], m_y [2], m_sx [2], m_sy [2], m_dx [2], m_dy [2];
  bit m_sel [2], m_half [2], m_mv [2], m_mh [2];
  bit m_fin;
  bit chk_en = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int w, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [wrap=%0d] @%0t: got %0d, expected %0d", nm, w, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fin = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_x[w] = 0; m_y[w] = 0; m_sel[w] = 0; m_half[w] = 0; m_mv[w] = 0;
      m_sx[w] = 0; m_sy[w] = 0; m_dx[w] = 0; m_dy[w] = 0; m_mh[w] = 0;
    end
  endtask

  task automatic model_load(input int lx, input int ly);
    for (int w = 0; w < 2; w++) begin
      m_x[w] = (lx > W - 1) ? W - 1 : lx;
      m_y[w] = (ly > H - 1) ? H - 1 : ly;
      m_sel[w] = 0; m_half[w] = 0;
    end
  endtask

  task automatic model_cmd(input int c);
    int ddx, ddy, tx, ty;
    bit inb;
    if (!game_active || c > 5) return;
    ddx = (c == 1) ? -1 : (c == 3) ? 1 : 0;
    ddy = (c == 0) ? -1 : (c == 2) ? 1 : 0;
    for (int w = 0; w < 2; w++) begin
      if (c == 4) m_sel[w] = !m_sel[w];
      else if (c == 5) begin
        if (m_sel[w]) m_half[w] = !m_half[w];
      end else begin
        tx = m_x[w] + ddx; ty = m_y[w] + ddy;
        inb = (tx >= 0) && (tx < W) && (ty >= 0) && (ty < H);
        if (!m_sel[w]) begin
          if (inb) begin m_x[w] = tx; m_y[w] = ty; end
          else if (w == 1) begin m_x[w] = (tx + W) % W; m_y[w] = (ty + H) % H; end
        end else if (inb) begin
          m_mv[w] = 1; m_sx[w] = m_x[w]; m_sy[w] = m_y[w];
          m_dx[w] = tx; m_dy[w] = ty; m_mh[w] = m_half[w];
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int w = 0; w < 2; w++) begin
        chk("key_read_fin", w, fin[w], m_fin);
        chk("cursor_x", w, cx[w], m_x[w]);
        chk("cursor_y", w, cy[w], m_y[w]);
        chk("selected", w, sel[w], m_sel[w]);
        chk("half", w, hlf[w], m_half[w]);
        chk("move_valid", w, mv[w], m_mv[w]);
        chk("move_src_x", w, sx[w], m_sx[w]);
        chk("move_src_y", w, sy[w], m_sy[w]);
        chk("move_dst_x", w, dx[w], m_dx[w]);
        chk("move_dst_y", w, dy[w], m_dy[w]);
        chk("move_half", w, mh[w], m_mh[w]);
      end
    end
  end

  // Decoder behaviour: ready held until after the read_fin pulse, plus linger.
  task automatic send_cmd(input int c, input int linger);
    @(negedge clock); key_ready = 1'b1; key_data = 3'(c);
    @(posedge clock); #1 m_fin = 1'b1;
    @(posedge clock); #1 m_fin = 1'b0; model_cmd(c);
    repeat (linger) @(posedge clock);
    #1 key_ready = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_load(input int lx, input int ly);
    @(negedge clock); cursor_load = 1'b1; load_x = 4'(lx); load_y = 4'(ly);
    @(posedge clock); #1 model_load(lx, ly); cursor_load = 1'b0;
  endtask

  task automatic do_ack(input bit ok, input bit ld, input int lx, input int ly);
    @(negedge clock);
    move_ack = 1'b1; move_ok = ok; cursor_load = ld; load_x = 4'(lx); load_y = 4'(ly);
    @(posedge clock); #1;
    for (int w = 0; w < 2; w++) begin
      if (m_mv[w]) begin
        m_mv[w] = 0; m_half[w] = 0;
        if (ok) begin m_x[w] = m_dx[w]; m_y[w] = m_dy[w]; end
        else m_sel[w] = 0;
      end
    end
    if (ld) model_load(lx, ly);
    move_ack = 1'b0; cursor_load = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1 model_reset();
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 chk_en = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("lit reset cursor_x", 0, cx[0], 0);
    chk("lit reset move_valid", 1, mv[1], 0);

    // Right step with ready lingering: exactly one step.
    send_cmd(3, 3);
    @(negedge clock);
    chk("lit step cursor_x", 0, cx[0], 1);
    chk("lit step cursor_y", 1, cy[1], 0);

    // Left at column 0: clamp vs wrap.
    do_load(0, 0);
    send_cmd(1, 0);
    @(negedge clock);
    chk("lit clamp cursor_x", 0, cx[0], 0);
    chk("lit wrap cursor_x", 1, cx[1], 15);

    // Select, half, down -> move request held until ack.
    do_load(3, 4);
    send_cmd(4, 0);
    send_cmd(5, 0);
    send_cmd(2, 0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("lit req valid", 0, mv[0], 1);
    chk("lit req dst_y", 0, dy[0], 5);
    chk("lit req src_y", 1, sy[1], 4);
    chk("lit req half", 1, mh[1], 1);
    do_ack(1'b1, 1'b0, 0, 0);
    @(negedge clock);
    chk("lit ack cursor_y", 0, cy[0], 5);
    chk("lit ack selected", 0, sel[0], 1);
    chk("lit ack half", 0, hlf[0], 0);

    // Rejected move: cursor stays, selection drops.
    do_load(3, 4);
    send_cmd(4, 0);
    send_cmd(0, 0);
    do_ack(1'b0, 1'b0, 0, 0);
    @(negedge clock);
    chk("lit nak cursor_y", 0, cy[0], 4);
    chk("lit nak selected", 1, sel[1], 0);

    // Off-board move from the corner, also with WRAP=1.
    do_load(15, 15);
    send_cmd(4, 0);
    send_cmd(3, 0);
    @(negedge clock);
    chk("lit corner valid", 1, mv[1], 0);
    chk("lit corner cursor_x", 1, cx[1], 15);
    chk("lit corner selected", 1, sel[1], 1);

    // Load coinciding with ack wins.
    send_cmd(0, 0);
    do_ack(1'b1, 1'b1, 2, 2);
    @(negedge clock);
    chk("lit ackload cursor_y", 0, cy[0], 2);
    chk("lit ackload selected", 0, sel[0], 0);

    // Inactive game and a reserved code: consumed, no effect.
    @(negedge clock); game_active = 1'b0;
    send_cmd(3, 1);
    @(negedge clock); game_active = 1'b1;
    send_cmd(6, 0);
    @(negedge clock);
    chk("lit inactive cursor_x", 0, cx[0], 2);

    // Reset while a request is pending.
    do_load(5, 5);
    send_cmd(4, 0);
    send_cmd(2, 0);
    do_reset();
    @(negedge clock);
    chk("lit rst valid", 0, mv[0], 0);
    chk("lit rst cursor_y", 1, cy[1], 0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion before 100000");
    $fatal(1);
  end

endmodule

// File: doc/keyboard_command_unit.md
Name: keyboard_command_unit

Overview:
Consumes 3-bit key commands from the PS/2 keyboard decoder and turns them into cursor motion, selection state and army-move requests for the game logic. It owns the decoder handshake (key_ready/key_read_fin), the board cursor, the selected flag and the half-army flag. It issues one move request at a time and holds it until the game logic acknowledges it.

Parameters:
BOARD_W, 16, board columns (x range 0..BOARD_W-1)
BOARD_H, 16, board rows (y range 0..BOARD_H-1)
COORD_W, 4, coordinate width; must satisfy 2**COORD_W >= max(BOARD_W, BOARD_H)
WRAP, 0, 0 = clamp cursor at edges; 1 = wrap to opposite edge (cursor only, never moves)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
key_ready  in  1  decoder has a command; stays high until key_read_fin is seen
key_data  in  3  command: 000 up, 001 left, 010 down, 011 right, 100 select, 101 half; 110/111 reserved
key_read_fin  out  1  one-cycle pulse: command consumed
game_active  in  1  0 = commands are consumed and discarded
cursor_load  in  1  load cursor from load_x/load_y
load_x  in  COORD_W  load column
load_y  in  COORD_W  load row
cursor_x  out  COORD_W  cursor column
cursor_y  out  COORD_W  cursor row
selected  out  1  cursor cell is selected as move source
half  out  1  next move sends half the army
move_valid  out  1  move request pending
move_src_x, move_src_y  out  COORD_W each  source cell
move_dst_x, move_dst_y  out  COORD_W each  destination cell
move_half  out  1  half flag captured with the request
move_ack  in  1  game logic accepts the request (valid while move_valid=1)
move_ok  in  1  with move_ack: 1 = move executed, 0 = rejected

Behaviour:
- Reset: state IDLE, key_read_fin=0, cursor=(0,0), selected=0, half=0, move_valid=0, all move_* payloads 0. Reset mid-request drops move_valid in the next cycle without waiting for ack.
- All outputs are registered.
- FSM states: IDLE, EXEC, MOVE_REQ, DRAIN.
- IDLE: when key_ready=1, latch key_data into cmd, set key_read_fin=1 for the next cycle only, go to EXEC.
- EXEC (key_read_fin high this cycle, low after). Apply cmd, then go to DRAIN unless noted:
  - game_active=0 or cmd reserved: no effect.
  - select: toggle selected.
  - half: toggle half. Honoured only when selected=1; otherwise no effect.
  - Direction with selected=0: step the cursor. At an edge, WRAP=0 leaves the cursor unchanged; WRAP=1 wraps it (e.g. x=0 left → BOARD_W-1).
  - Direction with selected=1 and target inside the board:
    - capture src=cursor, dst=neighbour cell, move_half=half.
    - assert move_valid and go to MOVE_REQ.
  - Direction with selected=1 and target off-board: no move and no wrap; selected stays 1.
- MOVE_REQ: hold move_valid and the payload stable until move_ack=1 (acceptance happens in the same cycle).
  - On ack: move_valid=0 next cycle; half=0.
  - If move_ok=1: cursor=dst and selected stays 1. If move_ok=0: cursor unchanged and selected=0.
  - Then go to DRAIN.
- DRAIN: wait for key_ready=0, then go to IDLE. This prevents double-consuming a command, since the decoder deasserts ready one cycle after key_read_fin.
- cursor_load: honoured in any state. It sets the cursor to (load_x, load_y), clamped to the board, and clears selected and half.
  - It does not alter a pending move payload or move_valid.
  - If cursor_load coincides with an ack, cursor_load wins over the cursor and selected updates from that ack.
- Latency: key_ready rising at cycle N gives key_read_fin at N+1 and a cursor/flag update visible at N+2. move_valid also rises at N+2.
- key_read_fin is never high for more than one consecutive cycle.

Decomposition:
- Package keyboard_cmd_pkg holds:
  - the 3-bit command enum (CMD_UP, CMD_LEFT, CMD_DOWN, CMD_RIGHT, CMD_SELECT, CMD_HALF);
  - the FSM state enum;
  - a coordinate struct {x, y}.
  The decoder is to adopt the same enum.
- Sub-module coord_stepper: combinational. Inputs: coordinate, direction, WRAP. Outputs: next coordinate and off_edge flag. It is used once for cursor steps and once for the move target.

Test Plan:
- Reset, then key_data=011 with key_ready held until read_fin → exactly one read_fin pulse; cursor=(1,0) at N+2; no second step while ready lingers.
- WRAP=0, cursor (0,0), cmd 001 → cursor stays (0,0). WRAP=1, same stimulus → cursor=(15,0).
- Cursor (3,4), cmd 100 then 101 then 010 → move_valid=1 with src (3,4), dst (3,5), move_half=1. Hold move_ack=0 for 5 cycles → payload stable. Ack with move_ok=1 → cursor (3,5), selected=1, half=0.
- Selected at (3,4), cmd 000, ack with move_ok=0 → cursor (3,4), selected=0.
- Selected at (15,15), cmd 011 → no move_valid; selected stays 1 and cursor stays (15,15), even with WRAP=1.
- game_active=0, cmd 011 → read_fin pulses, cursor unchanged. Reset asserted during MOVE_REQ → move_valid=0 next cycle, all outputs at reset values.
